spi_frame_writer: RTL and testbench

SPI slave that receives pixel data from the ESP32 host and writes it into the two 256×16 LED frame-buffer RAMs. The LED matrix scan driver reads those same RAMs through their read ports, so this block is the write side of the frame-buffer interface. It owns the RAM write ports and nothing else, and produces one write strobe per received 16-bit word.

---
 rtl/spi_frame_writer_pkg.sv | 32 +++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_frame_writer.sv | 160 ++++++++++++++++
 tb/tb_spi_frame_writer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_writer_pkg.sv
// Shared types and constants for the SPI frame-buffer write path.
package spi_frame_writer_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_IGNORE  = 3'd5
  } state_t;

  localparam logic [1:0] TGT_BANK1 = 2'b00;
  localparam logic [1:0] TGT_BANK2 = 2'b01;
  localparam logic [1:0] TGT_BOTH  = 2'b10;

  // True when the command target includes frame buffer 1.
  function automatic logic hits_bank1(input logic [1:0] tgt);
    return (tgt == TGT_BANK1) || (tgt == TGT_BOTH);
  endfunction

  // True when the command target includes frame buffer 2.
  function automatic logic hits_bank2(input logic [1:0] tgt);
    return (tgt == TGT_BANK2) || (tgt == TGT_BOTH);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with registered rise/fall pulses; pin edge to pulse is STAGES+1 cycles.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus edge detector. Resets to 0 so a line already low at
  // reset release never produces a falling-edge pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_din};
      prev_q <= sync_q[STAGES-1];
      o_rise <= sync_q[STAGES-1] & ~prev_q;
      o_fall <= ~sync_q[STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/spi_frame_writer.sv
// SPI mode-0 slave that turns byte pairs into 16-bit writes on two frame-buffer RAMs.
module spi_frame_writer
  import spi_frame_writer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_sck,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic [ADDR_W-1:0] o_waddr_1,
  output logic [DATA_W-1:0] o_wdata_1,
  output logic              o_we_1,
  output logic [ADDR_W-1:0] o_waddr_2,
  output logic [DATA_W-1:0] o_wdata_2,
  output logic              o_we_2,
  output logic              o_frame_done
);

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BYTE_W-1:0]      shift_q;
  logic [1:0]             tgt_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [BYTE_W-1:0]      lo_q;
  logic                   wrote_q;
  logic [BYTE_W-1:0]      txn_cnt_q;
  logic [BYTE_W-1:0]      miso_sh_q;

  logic [BYTE_W-1:0]      byte_c;
  logic                   active_c;
  logic                   byte_done_c;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_din  (i_spi_sck),
    .o_rise (sck_rise),
    .o_fall (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_din  (i_spi_cs_n),
    .o_rise (cs_rise),
    .o_fall (cs_fall)
  );

  // MOSI only needs the synchronizer; it is stable around the SCK rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mosi_sync_q <= '0;
    else          mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a CS_N rise always wins over a coincident SCK edge.
  always_comb begin
    state_d     = state_q;
    byte_c      = {shift_q[BYTE_W-2:0], mosi_s};
    active_c    = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                  (state_q == ST_DATA_LO) || (state_q == ST_DATA_HI);
    byte_done_c = active_c && sck_rise && (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else if (cs_fall) begin
      state_d = ST_CMD;
    end else if (byte_done_c) begin
      case (state_q)
        ST_CMD:     state_d = (byte_c[7:6] == 2'b11) ? ST_IGNORE : ST_ADDR;
        ST_ADDR:    state_d = ST_DATA_LO;
        ST_DATA_LO: state_d = ST_DATA_HI;
        ST_DATA_HI: state_d = ST_DATA_LO;
        default:    state_d = state_q;
      endcase
    end
  end

  // Byte assembly, write strobes, MISO status shifter and transaction counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tgt_q        <= TGT_BANK1;
      addr_q       <= '0;
      lo_q         <= '0;
      wrote_q      <= 1'b0;
      txn_cnt_q    <= '0;
      miso_sh_q    <= '0;
      o_spi_miso   <= 1'b0;
      o_waddr_1    <= '0;
      o_wdata_1    <= '0;
      o_we_1       <= 1'b0;
      o_waddr_2    <= '0;
      o_wdata_2    <= '0;
      o_we_2       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_we_1       <= 1'b0;
      o_we_2       <= 1'b0;
      o_frame_done <= 1'b0;
      if (cs_rise) begin
        o_frame_done <= wrote_q;
        if (wrote_q) txn_cnt_q <= txn_cnt_q + 8'd1;
        wrote_q    <= 1'b0;
        bit_cnt_q  <= '0;
        o_spi_miso <= 1'b0;
      end else if (cs_fall) begin
        bit_cnt_q  <= '0;
        wrote_q    <= 1'b0;
        o_spi_miso <= txn_cnt_q[BYTE_W-1];
        miso_sh_q  <= {txn_cnt_q[BYTE_W-2:0], 1'b0};
      end else begin
        if (active_c && sck_rise) begin
          shift_q   <= byte_c;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (byte_done_c) begin
          case (state_q)
            ST_CMD: begin
              tgt_q      <= byte_c[7:6];
              o_spi_miso <= 1'b0;
            end
            ST_ADDR:    addr_q <= byte_c;
            ST_DATA_LO: lo_q   <= byte_c;
            ST_DATA_HI: begin
              o_waddr_1 <= addr_q;
              o_waddr_2 <= addr_q;
              o_wdata_1 <= {byte_c, lo_q};
              o_wdata_2 <= {byte_c, lo_q};
              o_we_1    <= hits_bank1(tgt_q);
              o_we_2    <= hits_bank2(tgt_q);
              addr_q    <= addr_q + 8'd1;
              wrote_q   <= 1'b1;
            end
            default: ;
          endcase
        end
        if (sck_fall && (state_q == ST_CMD)) begin
          o_spi_miso <= miso_sh_q[BYTE_W-1];
          miso_sh_q  <= {miso_sh_q[BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_writer.sv
// Directed bench: table of SPI transactions plus a mid-transaction reset sequence.
module tb_spi_frame_writer;

  logic clk, rst_n, sck, cs_n, mosi;
  logic miso;
  logic [7:0]  waddr_1, waddr_2;
  logic [15:0] wdata_1, wdata_2;
  logic we_1, we_2, frame_done;

  spi_frame_writer #(.SYNC_STAGES(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_spi_sck   (sck),
    .i_spi_cs_n  (cs_n),
    .i_spi_mosi  (mosi),
    .o_spi_miso  (miso),
    .o_waddr_1   (waddr_1),
    .o_wdata_1   (wdata_1),
    .o_we_1      (we_1),
    .o_waddr_2   (waddr_2),
    .o_wdata_2   (wdata_2),
    .o_we_2      (we_2),
    .o_frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [23:0] q1[$];
  logic [23:0] q2[$];
  int done_cnt = 0;
  int wide = 0;
  int mirror_bad = 0;
  logic we1_prev = 1'b0, we2_prev = 1'b0, done_prev = 1'b0;

  // Write/frame-done monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (we_1) begin
      q1.push_back({waddr_1, wdata_1});
      if (waddr_1 !== waddr_2 || wdata_1 !== wdata_2) mirror_bad++;
    end
    if (we_2) begin
      q2.push_back({waddr_2, wdata_2});
      if (waddr_1 !== waddr_2 || wdata_1 !== wdata_2) mirror_bad++;
    end
    if (frame_done) done_cnt++;
    if ((we_1 && we1_prev) || (we_2 && we2_prev) || (frame_done && done_prev)) wide++;
    we1_prev  = we_1;
    we2_prev  = we_2;
    done_prev = frame_done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    #80;
    m = miso;
    sck = 1'b1;
    #80;
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], m[i]);
  endtask

  typedef struct {
    logic [7:0]       cmd;
    logic [7:0]       addr;
    int               n;
    logic [9:0][7:0]  d;
    int               nw;
    logic [1:0]       mask;
    logic [2:0][7:0]  wa;
    logic [2:0][15:0] wd;
    logic             done;
  } vec_t;

  task automatic spi_txn(input vec_t v, output logic [7:0] m_cmd, output logic [7:0] m_addr);
    logic [7:0] dummy;
    cs_n = 1'b0;
    #80;
    spi_byte(v.cmd, m_cmd);
    spi_byte(v.addr, m_addr);
    for (int i = 0; i < v.n; i++) spi_byte(v.d[i], dummy);
    #80;
    cs_n = 1'b1;
    #200;
  endtask

  vec_t vecs[7];
  vec_t rv;
  logic [7:0] exp_txn;
  logic [7:0] m_cmd, m_addr, m_tmp;
  logic bit_tmp;
  int exp1, exp2;

  initial begin
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    exp_txn = 8'd0;

    for (int i = 0; i < 7; i++) begin
      vecs[i].d = '0; vecs[i].wa = '0; vecs[i].wd = '0;
    end
    vecs[0].cmd = 8'h00; vecs[0].addr = 8'h10; vecs[0].n = 2;
    vecs[0].d[0] = 8'h34; vecs[0].d[1] = 8'h12;
    vecs[0].nw = 1; vecs[0].mask = 2'b01; vecs[0].wa[0] = 8'h10; vecs[0].wd[0] = 16'h1234;
    vecs[0].done = 1'b1;

    vecs[1].cmd = 8'h80; vecs[1].addr = 8'hFE; vecs[1].n = 6;
    vecs[1].d[0] = 8'h01; vecs[1].d[1] = 8'hAA; vecs[1].d[2] = 8'h02;
    vecs[1].d[3] = 8'hBB; vecs[1].d[4] = 8'h03; vecs[1].d[5] = 8'hCC;
    vecs[1].nw = 3; vecs[1].mask = 2'b11;
    vecs[1].wa[0] = 8'hFE; vecs[1].wa[1] = 8'hFF; vecs[1].wa[2] = 8'h00;
    vecs[1].wd[0] = 16'hAA01; vecs[1].wd[1] = 16'hBB02; vecs[1].wd[2] = 16'hCC03;
    vecs[1].done = 1'b1;

    vecs[2].cmd = 8'h40; vecs[2].addr = 8'h05; vecs[2].n = 1; vecs[2].d[0] = 8'h77;
    vecs[2].nw = 0; vecs[2].mask = 2'b10; vecs[2].done = 1'b0;

    vecs[3].cmd = 8'hC0; vecs[3].addr = 8'h11; vecs[3].n = 9;
    for (int i = 0; i < 9; i++) vecs[3].d[i] = 8'(8'h21 + i);
    vecs[3].nw = 0; vecs[3].mask = 2'b00; vecs[3].done = 1'b0;

    vecs[4].cmd = 8'h00; vecs[4].addr = 8'h20; vecs[4].n = 2;
    vecs[4].d[0] = 8'h55; vecs[4].d[1] = 8'h66;
    vecs[4].nw = 1; vecs[4].mask = 2'b01; vecs[4].wa[0] = 8'h20; vecs[4].wd[0] = 16'h6655;
    vecs[4].done = 1'b1;

    vecs[5].cmd = 8'h41; vecs[5].addr = 8'h7F; vecs[5].n = 2;
    vecs[5].d[0] = 8'hAB; vecs[5].d[1] = 8'hCD;
    vecs[5].nw = 1; vecs[5].mask = 2'b10; vecs[5].wa[0] = 8'h7F; vecs[5].wd[0] = 16'hCDAB;
    vecs[5].done = 1'b1;

    vecs[6].cmd = 8'h3F; vecs[6].addr = 8'h3C; vecs[6].n = 3;
    vecs[6].d[0] = 8'h11; vecs[6].d[1] = 8'h22; vecs[6].d[2] = 8'h33;
    vecs[6].nw = 1; vecs[6].mask = 2'b01; vecs[6].wa[0] = 8'h3C; vecs[6].wd[0] = 16'h2211;
    vecs[6].done = 1'b1;

    // Reset values.
    #21;
    chk("rst_we1", 32'(we_1), 32'd0);
    chk("rst_we2", 32'(we_2), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_waddr1", 32'(waddr_1), 32'd0);
    chk("rst_wdata2", 32'(wdata_2), 32'd0);
    #29;
    rst_n = 1'b1;
    #100;

    for (int v = 0; v < 7; v++) begin
      q1.delete(); q2.delete(); done_cnt = 0;
      spi_txn(vecs[v], m_cmd, m_addr);
      chk($sformatf("v%0d_miso_cmd", v), 32'(m_cmd), 32'(exp_txn));
      chk($sformatf("v%0d_miso_addr", v), 32'(m_addr), 32'd0);
      exp1 = vecs[v].mask[0] ? vecs[v].nw : 0;
      exp2 = vecs[v].mask[1] ? vecs[v].nw : 0;
      chk($sformatf("v%0d_n_we1", v), 32'(q1.size()), 32'(exp1));
      chk($sformatf("v%0d_n_we2", v), 32'(q2.size()), 32'(exp2));
      for (int j = 0; j < exp1; j++)
        if (j < q1.size())
          chk($sformatf("v%0d_w1_%0d", v, j), 32'(q1[j]), 32'({vecs[v].wa[j], vecs[v].wd[j]}));
      for (int j = 0; j < exp2; j++)
        if (j < q2.size())
          chk($sformatf("v%0d_w2_%0d", v, j), 32'(q2[j]), 32'({vecs[v].wa[j], vecs[v].wd[j]}));
      chk($sformatf("v%0d_done", v), 32'(done_cnt), 32'(vecs[v].done));
      if (vecs[v].done) exp_txn = exp_txn + 8'd1;
    end

    // Reset pulsed after 12 SCK edges of a pair: no write, async output clear.
    q1.delete(); q2.delete(); done_cnt = 0;
    cs_n = 1'b0;
    #80;
    spi_byte(8'h00, m_tmp);
    spi_byte(8'h40, m_tmp);
    spi_byte(8'h5A, m_tmp);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, bit_tmp);
    #40;
    rst_n = 1'b0;
    #1;
    chk("arst_waddr1", 32'(waddr_1), 32'd0);
    chk("arst_wdata1", 32'(wdata_1), 32'd0);
    chk("arst_waddr2", 32'(waddr_2), 32'd0);
    chk("arst_wdata2", 32'(wdata_2), 32'd0);
    chk("arst_we", 32'({we_1, we_2, frame_done, miso}), 32'd0);
    #49;
    cs_n = 1'b1;
    #50;
    rst_n = 1'b1;
    #200;
    chk("arst_no_write", 32'(q1.size() + q2.size()), 32'd0);
    chk("arst_no_done", 32'(done_cnt), 32'd0);
    exp_txn = 8'd0;

    rv = vecs[0];
    rv.addr = 8'h33; rv.d[0] = 8'h9A; rv.d[1] = 8'h78;
    q1.delete(); q2.delete(); done_cnt = 0;
    spi_txn(rv, m_cmd, m_addr);
    chk("post_miso_cmd", 32'(m_cmd), 32'(exp_txn));
    chk("post_n_we1", 32'(q1.size()), 32'd1);
    chk("post_n_we2", 32'(q2.size()), 32'd0);
    if (q1.size() > 0) chk("post_w1", 32'(q1[0]), 32'h0033789A);
    chk("post_done", 32'(done_cnt), 32'd1);

    chk("pulse_width", 32'(wide), 32'd0);
    chk("bank_mirror", 32'(mirror_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
